// File: rtl/sp_ram_pkg.sv
// Shared definitions for the pipelined single-port RAM.
// Holds the read-during-write mode encodings and the controller state enum
// so the top and the storage core agree on them.
package sp_ram_pkg;

  // Response to an accepted write: the word before the write, the merged
  // word after it, or no response at all.
  localparam int RD_READ_FIRST  = 0;
  localparam int RD_WRITE_FIRST = 1;
  localparam int RD_NO_CHANGE   = 2;

  // CLEAR walks the array writing zeros; READY accepts requests.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

endpackage

// File: rtl/sp_ram_core.sv
// Storage array for the pipelined single-port RAM.
// One shared address, byte-enable write, registered read of the word held
// before the write (read-first).  No reset, so it maps onto block RAM.
// Ports:
//   clk   - rising-edge clock
//   en    - access enable; rdata only updates on enabled cycles
//   we    - write when high
//   be    - byte enables, bit i covers wdata[8i+7:8i]
//   addr  - word address, must be below DEPTH when en is high
//   wdata - write data
//   rdata - registered read data
module sp_ram_core
  import sp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Read-first: rdata captures the stored word in the same edge that the
  // write lands, so it always reflects memory before this access.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < NB; i++) begin
          if (be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/singleport_ram_pipe.sv
// Pipelined single-port RAM with zero-fill controller.
// Accepts one read or byte-masked write per cycle while ready, returns a
// response 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1) later, and can zero
// the whole array after reset or on a clr pulse.
// Ports:
//   clk    - rising-edge clock
//   rst    - asynchronous active-high reset
//   req    - access request, taken when ready is high
//   we     - 1 = write, 0 = read
//   be     - byte write enables
//   addr   - word address; addresses >= DEPTH read as zero, writes dropped
//   wdata  - write data
//   clr    - pulse in READY starts a zero-fill
//   ready  - high when requests are accepted
//   rvalid - one-cycle pulse marking valid rdata
//   rdata  - response data, held while rvalid is low
module singleport_ram_pipe
  import sp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 6,
  parameter int DATA_WIDTH     = 8,
  parameter int DEPTH          = 64,
  parameter int RD_MODE        = 0,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic                    clr,
  output logic                    ready,
  output logic                    rvalid,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   clr_cnt;
  logic                    clearing;
  logic                    accept;
  logic                    in_range;

  logic                    core_en;
  logic                    core_we;
  logic [NB-1:0]           core_be;
  logic [ADDR_WIDTH-1:0]   core_addr;
  logic [DATA_WIDTH-1:0]   core_wdata;
  logic [DATA_WIDTH-1:0]   core_rdata;

  logic                    s1_valid;
  logic                    s1_oor;
  logic                    s1_write;
  logic [NB-1:0]           s1_be;
  logic [DATA_WIDTH-1:0]   s1_wdata;
  logic [DATA_WIDTH-1:0]   byte_mask;
  logic [DATA_WIDTH-1:0]   s1_data;

  assign clearing = (state == ST_CLEAR);
  assign ready    = (state == ST_READY);
  assign accept   = req && ready;
  // Extra bit keeps the compare correct when DEPTH == 2**ADDR_WIDTH.
  assign in_range = ({1'b0, addr} < DEPTH_EXT);

  // Controller: the fill writes one address per cycle and leaves CLEAR on
  // the edge that writes DEPTH-1, so CLEAR lasts exactly DEPTH cycles.
  // clr is only looked at in READY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RESET_STATE;
      clr_cnt <= '0;
    end else if (state == ST_CLEAR) begin
      if (clr_cnt == LAST_ADDR) begin
        state   <= ST_READY;
        clr_cnt <= '0;
      end else begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end else if (clr) begin
      state   <= ST_CLEAR;
      clr_cnt <= '0;
    end
  end

  // The fill owns the single port while clearing; otherwise accepted
  // in-range requests drive it.  Out-of-range accesses never touch memory.
  always_comb begin
    core_en    = clearing || (accept && in_range);
    core_we    = clearing || we;
    core_be    = clearing ? {NB{1'b1}} : be;
    core_addr  = clearing ? clr_cnt : addr;
    core_wdata = clearing ? '0 : wdata;
  end

  sp_ram_core #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_core (
    .clk   (clk),
    .en    (core_en),
    .we    (core_we),
    .be    (core_be),
    .addr  (core_addr),
    .wdata (core_wdata),
    .rdata (core_rdata)
  );

  // Stage 1 tracks what the word coming out of the core means.  No-change
  // writes never enter the response pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_oor   <= 1'b0;
      s1_write <= 1'b0;
      s1_be    <= '0;
      s1_wdata <= '0;
    end else begin
      s1_valid <= accept && !(we && (RD_MODE == RD_NO_CHANGE));
      s1_oor   <= !in_range;
      s1_write <= we;
      s1_be    <= be;
      s1_wdata <= wdata;
    end
  end

  // The core is read-first, so write-first responses are rebuilt by merging
  // the enabled bytes of the write data over the old word.
  always_comb begin
    byte_mask = '0;
    for (int i = 0; i < NB; i++) begin
      byte_mask[8*i +: 8] = {8{s1_be[i]}};
    end
    s1_data = core_rdata;
    if (s1_oor) begin
      s1_data = '0;
    end else if (s1_write && (RD_MODE == RD_WRITE_FIRST)) begin
      s1_data = (core_rdata & ~byte_mask) | (s1_wdata & byte_mask);
    end
  end

  // Core output moves on fills and silent writes, so rdata is taken from a
  // register that only updates on real responses.
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic                  out_valid;
      logic [DATA_WIDTH-1:0] out_data;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          out_valid <= 1'b0;
          out_data  <= '0;
        end else begin
          out_valid <= s1_valid;
          if (s1_valid) begin
            out_data <= s1_data;
          end
        end
      end

      assign rvalid = out_valid;
      assign rdata  = out_data;
    end else begin : g_out_direct
      logic [DATA_WIDTH-1:0] hold_data;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hold_data <= '0;
        end else if (s1_valid) begin
          hold_data <= s1_data;
        end
      end

      assign rvalid = s1_valid;
      assign rdata  = s1_valid ? s1_data : hold_data;
    end
  endgenerate

endmodule

// File: tb/tb_singleport_ram_pipe.sv
// Bench for singleport_ram_pipe.  Five configurations share one stimulus:
//   d0: 8-bit,  DEPTH 64, read-first,  direct output
//   d1: 8-bit,  DEPTH 64, write-first, output register
//   d2: 8-bit,  DEPTH 64, no-change,   direct output
//   d3: 16-bit, DEPTH 48, read-first,  output register
//   d4: 8-bit,  DEPTH 64, no clear on reset (reset behaviour only)
// 8-bit instances see the low byte of wdata and be[0].
module tb_singleport_ram_pipe;

  typedef struct {
    logic             we;
    logic [1:0]       be;
    logic [5:0]       addr;
    logic [15:0]      wdata;
    logic [3:0]       ev;
    logic [3:0][15:0] ed;
  } vec_t;

  localparam logic [3:0] OREG = 4'b1010;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic        clr;
  logic [1:0]  be;
  logic [5:0]  addr;
  logic [15:0] wdata;

  logic [4:0]  ready_v;
  logic [4:0]  rvalid_v;
  logic [7:0]  rd0, rd1, rd2, rd4;
  logic [15:0] rd3;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] last [4];
  vec_t        vecs [13];
  logic [3:0]  bev [4];
  logic [15:0] bed [4][4];
  int          low_a, low_b, pulses;

  always #5 clk = ~clk;

  singleport_ram_pipe #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .DEPTH(64), .RD_MODE(0),
    .OUT_REG(0), .CLEAR_ON_RESET(1)) dut0 (
    .clk(clk), .rst(rst), .req(req), .we(we), .be(be[0:0]), .addr(addr),
    .wdata(wdata[7:0]), .clr(clr), .ready(ready_v[0]), .rvalid(rvalid_v[0]), .rdata(rd0));

  singleport_ram_pipe #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .DEPTH(64), .RD_MODE(1),
    .OUT_REG(1), .CLEAR_ON_RESET(1)) dut1 (
    .clk(clk), .rst(rst), .req(req), .we(we), .be(be[0:0]), .addr(addr),
    .wdata(wdata[7:0]), .clr(clr), .ready(ready_v[1]), .rvalid(rvalid_v[1]), .rdata(rd1));

  singleport_ram_pipe #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .DEPTH(64), .RD_MODE(2),
    .OUT_REG(0), .CLEAR_ON_RESET(1)) dut2 (
    .clk(clk), .rst(rst), .req(req), .we(we), .be(be[0:0]), .addr(addr),
    .wdata(wdata[7:0]), .clr(clr), .ready(ready_v[2]), .rvalid(rvalid_v[2]), .rdata(rd2));

  singleport_ram_pipe #(.ADDR_WIDTH(6), .DATA_WIDTH(16), .DEPTH(48), .RD_MODE(0),
    .OUT_REG(1), .CLEAR_ON_RESET(1)) dut3 (
    .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .addr(addr),
    .wdata(wdata), .clr(clr), .ready(ready_v[3]), .rvalid(rvalid_v[3]), .rdata(rd3));

  singleport_ram_pipe #(.ADDR_WIDTH(6), .DATA_WIDTH(8), .DEPTH(64), .RD_MODE(0),
    .OUT_REG(0), .CLEAR_ON_RESET(0)) dut4 (
    .clk(clk), .rst(rst), .req(req), .we(we), .be(be[0:0]), .addr(addr),
    .wdata(wdata[7:0]), .clr(clr), .ready(ready_v[4]), .rvalid(rvalid_v[4]), .rdata(rd4));

  // Widen each instance's rdata to a common 16-bit view.
  function automatic logic [15:0] rdOf(input int i);
    case (i)
      0:       return {8'h00, rd0};
      1:       return {8'h00, rd1};
      2:       return {8'h00, rd2};
      3:       return rd3;
      default: return {8'h00, rd4};
    endcase
  endfunction

  function automatic vec_t mkVec(input logic w, input logic [1:0] b, input logic [5:0] a,
                                 input logic [15:0] d, input logic [3:0] ev,
                                 input logic [15:0] e0, input logic [15:0] e1,
                                 input logic [15:0] e2, input logic [15:0] e3);
    vec_t v;
    v.we = w; v.be = b; v.addr = a; v.wdata = d; v.ev = ev;
    v.ed[0] = e0; v.ed[1] = e1; v.ed[2] = e2; v.ed[3] = e3;
    return v;
  endfunction

  // One comparison: counts it, and reports it when it differs.
  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Checks all four main instances at sample s (1 or 2 cycles after the
  // accepting edge).  An instance answers only at its own latency; at the
  // other sample rvalid must be low and rdata must hold its last response.
  task automatic sampleAll(input int s, input vec_t v, input int idx);
    logic        expv;
    logic [15:0] expd;
    for (int i = 0; i < 4; i++) begin
      if ((OREG[i] ? 2 : 1) == s) begin
        expv = v.ev[i];
        expd = v.ev[i] ? v.ed[i] : last[i];
      end else begin
        expv = 1'b0;
        expd = last[i];
      end
      checkOutput($sformatf("v%0d s%0d d%0d rvalid", idx, s, i), {15'b0, rvalid_v[i]}, {15'b0, expv});
      checkOutput($sformatf("v%0d s%0d d%0d rdata", idx, s, i), rdOf(i), expd);
      if (expv) last[i] = expd;
    end
  endtask

  // Issues a single request and checks both response slots.
  task automatic applyStimulus(input vec_t v, input int idx);
    @(negedge clk);
    req = 1'b1; we = v.we; be = v.be; addr = v.addr; wdata = v.wdata;
    @(negedge clk);
    req = 1'b0;
    sampleAll(1, v, idx);
    @(negedge clk);
    sampleAll(2, v, idx);
  endtask

  // Counts ready-low samples for a 64-deep and the 48-deep instance,
  // starting at the current negedge.
  task automatic countLow(output int a, output int b);
    a = 0; b = 0;
    for (int k = 0; k < 72; k++) begin
      if (!ready_v[0]) a++;
      if (!ready_v[3]) b++;
      @(negedge clk);
    end
  endtask

  task automatic checkInReset(input string tag);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("%s d%0d ready", tag, i), {15'b0, ready_v[i]}, 16'h0);
      checkOutput($sformatf("%s d%0d rvalid", tag, i), {15'b0, rvalid_v[i]}, 16'h0);
      checkOutput($sformatf("%s d%0d rdata", tag, i), rdOf(i), 16'h0);
    end
    checkOutput({tag, " d4 ready"}, {15'b0, ready_v[4]}, 16'h1);
    checkOutput({tag, " d4 rvalid"}, {15'b0, rvalid_v[4]}, 16'h0);
    checkOutput({tag, " d4 rdata"}, rdOf(4), 16'h0);
  endtask

  initial begin
    // Expected values in order d0, d1, d2, d3; ev bit i marks an rvalid.
    vecs[0]  = mkVec(0, 2'b11, 6'd5,  16'h0000, 4'b1111, 16'h00, 16'h00, 16'h00, 16'h0000);
    vecs[1]  = mkVec(1, 2'b11, 6'd3,  16'h00A5, 4'b1011, 16'h00, 16'hA5, 16'h00, 16'h0000);
    vecs[2]  = mkVec(0, 2'b11, 6'd3,  16'h0000, 4'b1111, 16'hA5, 16'hA5, 16'hA5, 16'h00A5);
    vecs[3]  = mkVec(1, 2'b11, 6'd9,  16'h0011, 4'b1011, 16'h00, 16'h11, 16'h00, 16'h0000);
    vecs[4]  = mkVec(1, 2'b11, 6'd9,  16'h0055, 4'b1011, 16'h11, 16'h55, 16'h00, 16'h0011);
    vecs[5]  = mkVec(0, 2'b11, 6'd9,  16'h0000, 4'b1111, 16'h55, 16'h55, 16'h55, 16'h0055);
    vecs[6]  = mkVec(1, 2'b11, 6'd7,  16'h1234, 4'b1011, 16'h00, 16'h34, 16'h00, 16'h0000);
    vecs[7]  = mkVec(1, 2'b10, 6'd7,  16'hFFFF, 4'b1011, 16'h34, 16'h34, 16'h00, 16'h1234);
    vecs[8]  = mkVec(0, 2'b11, 6'd7,  16'h0000, 4'b1111, 16'h34, 16'h34, 16'h34, 16'hFF34);
    vecs[9]  = mkVec(1, 2'b11, 6'd50, 16'h00EE, 4'b1011, 16'h00, 16'hEE, 16'h00, 16'h0000);
    vecs[10] = mkVec(0, 2'b11, 6'd50, 16'h0000, 4'b1111, 16'hEE, 16'hEE, 16'hEE, 16'h0000);
    vecs[11] = mkVec(1, 2'b00, 6'd12, 16'h00CC, 4'b1011, 16'h00, 16'h00, 16'h00, 16'h0000);
    vecs[12] = mkVec(0, 2'b11, 6'd12, 16'h0000, 4'b1111, 16'h00, 16'h00, 16'h00, 16'h0000);

    // Burst: write 20, read 20, read 3 on consecutive edges; samples N1..N4.
    bev[0] = 4'b0001; bed[0] = '{16'h00, 16'h00, 16'h00, 16'h0000};
    bev[1] = 4'b1111; bed[1] = '{16'h77, 16'h77, 16'h77, 16'h0000};
    bev[2] = 4'b1111; bed[2] = '{16'hA5, 16'h77, 16'hA5, 16'h0077};
    bev[3] = 4'b1010; bed[3] = '{16'hA5, 16'hA5, 16'hA5, 16'h00A5};

    for (int i = 0; i < 4; i++) last[i] = 16'h0;

    rst = 1'b1; req = 1'b0; we = 1'b0; be = 2'b00; addr = '0; wdata = '0; clr = 1'b0;
    repeat (3) @(negedge clk);
    checkInReset("reset");

    // Initial fill after reset release.
    rst = 1'b0;
    countLow(low_a, low_b);
    checkOutput("fill64 low cycles", 16'(low_a), 16'd64);
    checkOutput("fill48 low cycles", 16'(low_b), 16'd48);
    checkOutput("ready after fill", {11'b0, ready_v}, 16'h001F);

    for (int k = 0; k < 13; k++) applyStimulus(vecs[k], k);

    // Back-to-back traffic including read-after-write.
    @(negedge clk);
    req = 1'b1; we = 1'b1; be = 2'b11; addr = 6'd20; wdata = 16'h0077;
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("burst s%0d d%0d rvalid", s, i), {15'b0, rvalid_v[i]}, {15'b0, bev[s][i]});
        checkOutput($sformatf("burst s%0d d%0d rdata", s, i), rdOf(i), bed[s][i]);
      end
      if (s == 0) begin we = 1'b0; addr = 6'd20; end
      else if (s == 1) addr = 6'd3;
      else req = 1'b0;
    end
    for (int i = 0; i < 4; i++) last[i] = bed[3][i];

    // clr together with a read: the read completes with old data, then the
    // fill runs its full length; requests and a second clr during it are
    // ignored.
    @(negedge clk);
    clr = 1'b1; req = 1'b1; we = 1'b0; addr = 6'd3; be = 2'b11;
    low_a = 0; low_b = 0; pulses = 0;
    for (int c = 1; c <= 72; c++) begin
      @(negedge clk);
      if (c == 1) begin
        clr = 1'b0;
        checkOutput("clr d0 rvalid", {15'b0, rvalid_v[0]}, 16'h1);
        checkOutput("clr d0 rdata", rdOf(0), 16'h00A5);
        checkOutput("clr d2 rvalid", {15'b0, rvalid_v[2]}, 16'h1);
        checkOutput("clr d2 rdata", rdOf(2), 16'h00A5);
        checkOutput("clr d1 early", {15'b0, rvalid_v[1]}, 16'h0);
        checkOutput("clr d3 early", {15'b0, rvalid_v[3]}, 16'h0);
      end else if (c == 2) begin
        checkOutput("clr d1 rvalid", {15'b0, rvalid_v[1]}, 16'h1);
        checkOutput("clr d1 rdata", rdOf(1), 16'h00A5);
        checkOutput("clr d3 rvalid", {15'b0, rvalid_v[3]}, 16'h1);
        checkOutput("clr d3 rdata", rdOf(3), 16'h00A5);
        checkOutput("clr d0 single pulse", {15'b0, rvalid_v[0]}, 16'h0);
      end else begin
        pulses += $countones(rvalid_v[3:0]);
      end
      if (c == 20) clr = 1'b1;
      if (c == 21) clr = 1'b0;
      if (c == 40) req = 1'b0;
      if (!ready_v[0]) low_a++;
      if (!ready_v[3]) low_b++;
    end
    checkOutput("clear64 low cycles", 16'(low_a), 16'd64);
    checkOutput("clear48 low cycles", 16'(low_b), 16'd48);
    checkOutput("dropped req responses", 16'(pulses), 16'd0);
    last[0] = 16'hA5; last[1] = 16'hA5; last[2] = 16'hA5; last[3] = 16'h00A5;

    applyStimulus(mkVec(0, 2'b11, 6'd3, 16'h0000, 4'b1111, 16'h00, 16'h00, 16'h00, 16'h0000), 13);
    applyStimulus(mkVec(1, 2'b11, 6'd9, 16'h0066, 4'b1011, 16'h00, 16'h66, 16'h00, 16'h0000), 14);
    applyStimulus(mkVec(0, 2'b11, 6'd9, 16'h0000, 4'b1111, 16'h66, 16'h66, 16'h66, 16'h0066), 15);

    // Reset while the fill is at address 20, then a full restart.
    @(negedge clk);
    clr = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 1) clr = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    checkInReset("mid-fill reset");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) last[i] = 16'h0;
    countLow(low_a, low_b);
    checkOutput("refill64 low cycles", 16'(low_a), 16'd64);
    checkOutput("refill48 low cycles", 16'(low_b), 16'd48);

    applyStimulus(mkVec(0, 2'b11, 6'd9, 16'h0000, 4'b1111, 16'h00, 16'h00, 16'h00, 16'h0000), 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
